// File: rtl/store_access_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : store_access_sequencer
// Description : Turns single-cycle read/write/clear requests into timed
//               asynchronous strobe sequences for the 32 x 32-bit store lines
//               and captures read data from store Q.
// Revision    : 1.0 - initial release
// ============================================================================
module store_access_sequencer #(
  parameter int SETUP_CYCLES = 2,
  parameter int WRITE_CYCLES = 4,
  parameter int READ_CYCLES  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [4:0]  req_addr,
  input  logic [31:0] req_data,
  input  logic        clear_req,
  output logic        req_ready,
  output logic        op_done,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic [4:0]  store_A,
  output logic [31:0] store_D,
  output logic        store_CS_n,
  output logic        store_WE_n,
  output logic        store_OE_n,
  input  logic [31:0] store_Q
);

  localparam int c_max_ab     = (SETUP_CYCLES > WRITE_CYCLES) ? SETUP_CYCLES : WRITE_CYCLES;
  localparam int c_max_cycles = (c_max_ab > READ_CYCLES) ? c_max_ab : READ_CYCLES;
  localparam int c_cnt_w      = (c_max_cycles > 1) ? $clog2(c_max_cycles) : 1;

  localparam logic [c_cnt_w-1:0] c_setup_last = c_cnt_w'(SETUP_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_write_last = c_cnt_w'(WRITE_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_read_last  = c_cnt_w'(READ_CYCLES - 1);
  localparam logic [4:0]         c_last_line  = 5'd31;

  localparam logic [2:0] c_st_idle    = 3'd0;
  localparam logic [2:0] c_st_w_setup = 3'd1;
  localparam logic [2:0] c_st_w_pulse = 3'd2;
  localparam logic [2:0] c_st_w_hold  = 3'd3;
  localparam logic [2:0] c_st_r_wait  = 3'd4;

  logic [2:0]         state_q, state_d;
  logic [c_cnt_w-1:0] cnt_q, cnt_d;
  logic [4:0]         addr_q, addr_d;
  logic [31:0]        data_q, data_d;
  logic               clear_q, clear_d;
  logic               req_ready_q, req_ready_d;
  logic               op_done_q, op_done_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [31:0]        rsp_data_q, rsp_data_d;
  logic [4:0]         store_a_q, store_a_d;
  logic [31:0]        store_d_q, store_d_d;
  logic               cs_n_q, cs_n_d;
  logic               we_n_q, we_n_d;
  logic               oe_n_q, oe_n_d;

  // State register and all registered outputs; reset aborts any operation
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= c_st_idle;
      cnt_q       <= '0;
      addr_q      <= 5'd0;
      data_q      <= 32'd0;
      clear_q     <= 1'b0;
      req_ready_q <= 1'b0;
      op_done_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 32'd0;
      store_a_q   <= 5'd0;
      store_d_q   <= 32'd0;
      cs_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      clear_q     <= clear_d;
      req_ready_q <= req_ready_d;
      op_done_q   <= op_done_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      store_a_q   <= store_a_d;
      store_d_q   <= store_d_d;
      cs_n_q      <= cs_n_d;
      we_n_q      <= we_n_d;
      oe_n_q      <= oe_n_d;
    end
  end

  // Next-state: acceptance in IDLE (clear wins), phase counting, clear sweep stepping
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    clear_d = clear_q;
    case (state_q)
      c_st_idle: begin
        // req_ready_q is low only in the first cycle after reset
        if (req_ready_q) begin
          if (clear_req) begin
            clear_d = 1'b1;
            addr_d  = 5'd0;
            data_d  = 32'd0;
            cnt_d   = '0;
            state_d = c_st_w_setup;
          end else if (req_valid) begin
            clear_d = 1'b0;
            addr_d  = req_addr;
            data_d  = req_write ? req_data : 32'd0;
            cnt_d   = '0;
            state_d = req_write ? c_st_w_setup : c_st_r_wait;
          end
        end
      end
      c_st_w_setup: begin
        if (cnt_q == c_setup_last) begin
          cnt_d   = '0;
          state_d = c_st_w_pulse;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      c_st_w_pulse: begin
        if (cnt_q == c_write_last) begin
          cnt_d   = '0;
          state_d = c_st_w_hold;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      c_st_w_hold: begin
        if (clear_q && (addr_q != c_last_line)) begin
          addr_d  = addr_q + 5'd1;
          cnt_d   = '0;
          state_d = c_st_w_setup;
        end else begin
          clear_d = 1'b0;
          state_d = c_st_idle;
        end
      end
      c_st_r_wait: begin
        if (cnt_q == c_read_last) begin
          cnt_d   = '0;
          state_d = c_st_idle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = c_st_idle;
        cnt_d   = '0;
        clear_d = 1'b0;
      end
    endcase
  end

  // Outputs computed from the next state so every pin is a flop that changes on state entry
  always_comb begin
    req_ready_d = (state_d == c_st_idle);
    op_done_d   = (state_d == c_st_idle) &&
                  ((state_q == c_st_w_hold) || (state_q == c_st_r_wait));
    rsp_valid_d = (state_d == c_st_idle) && (state_q == c_st_r_wait);
    rsp_data_d  = rsp_valid_d ? store_Q : rsp_data_q;
    store_a_d   = addr_d;
    store_d_d   = ((state_d == c_st_w_setup) || (state_d == c_st_w_pulse) ||
                   (state_d == c_st_w_hold)) ? data_d : 32'd0;
    cs_n_d      = (state_d == c_st_idle);
    we_n_d      = (state_d != c_st_w_pulse);
    oe_n_d      = (state_d != c_st_r_wait);
  end

  assign req_ready  = req_ready_q;
  assign op_done    = op_done_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign store_A    = store_a_q;
  assign store_D    = store_d_q;
  assign store_CS_n = cs_n_q;
  assign store_WE_n = we_n_q;
  assign store_OE_n = oe_n_q;

endmodule
`default_nettype wire

// File: tb/tb_store_access_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_store_access_sequencer
// Description : Directed plus randomized bench for store_access_sequencer with
//               a behavioural store and a reference memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_store_access_sequencer;

  localparam int S       = 2;
  localparam int W       = 4;
  localparam int R       = 4;
  localparam int LAT_WR  = S + W + 2;
  localparam int LAT_RD  = R + 1;
  localparam int LAT_CLR = 32 * (S + W + 1) + 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [4:0]  req_addr = 5'd0;
  logic [31:0] req_data = 32'd0;
  logic        clear_req = 1'b0;
  logic        req_ready, op_done, rsp_valid;
  logic [31:0] rsp_data;
  logic [4:0]  store_A;
  logic [31:0] store_D;
  logic        store_CS_n, store_WE_n, store_OE_n;
  logic [31:0] store_Q;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [31:0] ref_mem [32];
  logic [31:0] last_rsp = 32'd0;

  store_access_sequencer #(
    .SETUP_CYCLES(S),
    .WRITE_CYCLES(W),
    .READ_CYCLES (R)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .clear_req (clear_req),
    .req_ready (req_ready),
    .op_done   (op_done),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .store_A   (store_A),
    .store_D   (store_D),
    .store_CS_n(store_CS_n),
    .store_WE_n(store_WE_n),
    .store_OE_n(store_OE_n),
    .store_Q   (store_Q)
  );

  always #100 clk = ~clk;

  // Behavioural store lines: zero-filled, written while CS_n and WE_n are low
  logic [31:0] store_mem [32] = '{default: 32'h0};
  always @(posedge clk) if (!store_CS_n && !store_WE_n) store_mem[store_A] <= store_D;
  assign store_Q = (!store_CS_n && !store_OE_n) ? store_mem[store_A] : 32'h0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Strobe-ordering monitor on every cycle
  logic        rst_at_edge = 1'b1;
  logic        prev_we_n = 1'b1;
  logic [4:0]  prev_a = 5'd0;
  logic [31:0] prev_d = 32'd0;
  int          we_run = 0;
  always @(posedge clk) rst_at_edge <= reset;
  always @(negedge clk) begin
    if (rst_at_edge) begin
      we_run = 0;
    end else begin
      check("we_oe_exclusive", 32'(store_WE_n | store_OE_n), 32'd1);
      if (!store_OE_n || store_CS_n) check("d_zero_outside_write", store_D, 32'd0);
      if (!store_WE_n) begin
        check("cs_low_during_we", 32'(store_CS_n), 32'd0);
        if (!prev_we_n) begin
          check("a_stable_we_low", 32'(store_A), 32'(prev_a));
          check("d_stable_we_low", store_D, prev_d);
        end
        we_run++;
      end else if (!prev_we_n) begin
        check("we_pulse_width", 32'(we_run), 32'(W));
        we_run = 0;
      end
    end
    prev_we_n = store_WE_n;
    prev_a    = store_A;
    prev_d    = store_D;
  end

  // kind: 0 read, 1 write, 2 clear. both: also raise req_valid with the clear.
  task automatic run_op(input int kind, input logic [4:0] a, input logic [31:0] d,
                        input bit both, input bit toggle);
    int waitc = 0;
    int lat = 0;
    int busy = 0;
    int we_lo = 0;
    int ad_bad = 0;
    int exp_lat;
    int exp_we;
    logic [31:0] exp_q;
    logic [31:0] exp_d;
    while (req_ready !== 1'b1 && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    check("ready_before_op", 32'(req_ready), 32'd1);
    check("rsp_data_hold", rsp_data, last_rsp);
    exp_lat = (kind == 0) ? LAT_RD : (kind == 1) ? LAT_WR : LAT_CLR;
    exp_we  = (kind == 0) ? 0 : (kind == 1) ? W : 32 * W;
    exp_q   = ref_mem[a];
    exp_d   = (kind == 1) ? d : 32'h0;
    clear_req = (kind == 2);
    req_valid = (kind != 2) || both;
    req_write = (kind == 1) || both;
    req_addr  = a;
    req_data  = d;
    do begin
      @(negedge clk);
      lat++;
      clear_req = 1'b0;
      req_valid = toggle ? 1'($urandom_range(0, 1)) : 1'b0;
      req_write = 1'($urandom_range(0, 1));
      req_addr  = 5'($urandom);
      req_data  = $urandom;
      if (req_ready !== 1'b1) busy++;
      if (store_WE_n === 1'b0) begin
        we_lo++;
        if (store_D !== exp_d || (kind == 1 && store_A !== a)) ad_bad++;
      end
    end while (op_done !== 1'b1 && lat < exp_lat + 20);
    req_valid = 1'b0;
    check("op_latency", 32'(lat), 32'(exp_lat));
    check("ready_low_cycles", 32'(busy), 32'(exp_lat - 1));
    check("we_low_cycles", 32'(we_lo), 32'(exp_we));
    check("addr_data_during_we", 32'(ad_bad), 32'd0);
    check("rsp_valid_at_done", 32'(rsp_valid), (kind == 0) ? 32'd1 : 32'd0);
    if (kind == 0) begin
      check("read_data", rsp_data, exp_q);
      last_rsp = exp_q;
    end else if (kind == 1) begin
      ref_mem[a] = d;
    end else begin
      for (int i = 0; i < 32; i++) ref_mem[i] = 32'h0;
    end
  endtask

  initial begin
    #(200 * 80000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 32; i++) ref_mem[i] = 32'h0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_op_done", 32'(op_done), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_store_A", 32'(store_A), 32'd0);
    check("rst_store_D", store_D, 32'd0);
    check("rst_strobes", 32'({store_CS_n, store_WE_n, store_OE_n}), 32'h7);
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_reset", 32'(req_ready), 32'd1);

    // Basic write / read
    run_op(1, 5'h00, 32'hDEADBEEF, 1'b0, 1'b0);
    run_op(0, 5'h00, 32'h0, 1'b0, 1'b0);
    run_op(0, 5'h1F, 32'h0, 1'b0, 1'b0);

    // Clear with simultaneous req_valid: clear must be taken
    run_op(1, 5'h1F, 32'hCAFEBABE, 1'b0, 1'b0);
    run_op(2, 5'h07, 32'h55AA55AA, 1'b1, 1'b0);
    run_op(0, 5'h00, 32'h0, 1'b0, 1'b0);
    run_op(0, 5'h10, 32'h0, 1'b0, 1'b0);
    run_op(0, 5'h1F, 32'h0, 1'b0, 1'b0);

    // Reset during cycle 4 of a write to 0x05
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 5'h05;
    req_data  = 32'hA5A55A5A;
    repeat (4) begin
      @(negedge clk);
      req_valid = 1'b0;
    end
    check("abort_we_low_c4", 32'(store_WE_n), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("abort_strobes_high", 32'({store_CS_n, store_WE_n, store_OE_n}), 32'h7);
    check("abort_no_done", 32'(op_done), 32'd0);
    check("abort_no_rsp", 32'(rsp_valid), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("abort_ready", 32'(req_ready), 32'd1);
    check("abort_no_done_after", 32'(op_done), 32'd0);
    last_rsp = 32'h0;
    run_op(1, 5'h05, 32'h12345678, 1'b0, 1'b0);
    run_op(0, 5'h05, 32'h0, 1'b0, 1'b0);

    // Back-to-back writes with req_valid toggled while busy
    run_op(1, 5'h0C, 32'h11111111, 1'b0, 1'b1);
    run_op(1, 5'h0D, 32'h22222222, 1'b0, 1'b1);
    run_op(0, 5'h0C, 32'h0, 1'b0, 1'b1);
    run_op(0, 5'h0D, 32'h0, 1'b0, 1'b1);

    // Randomized traffic against the reference memory
    for (int n = 0; n < 40; n++) begin
      int sel;
      sel = $urandom_range(0, 19);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      if (sel == 0)
        run_op(2, 5'h0, 32'h0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      else if (sel < 10)
        run_op(1, 5'($urandom), $urandom, 1'b0, 1'($urandom_range(0, 1)));
      else
        run_op(0, 5'($urandom), 32'h0, 1'b0, 1'($urandom_range(0, 1)));
    end

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/store_access_sequencer.md
Name: store_access_sequencer

Overview:
- Sits directly upstream of the 32 x 32-bit store-lines block.
- Converts single-cycle read/write requests from the Baby control logic into correctly timed asynchronous strobe sequences on the store's A, D, CS_n, WE_n and OE_n pins, and captures Q on reads.
- Also implements the "clear store" operation, which writes zero to all 32 lines in sequence.

Parameters:
- SETUP_CYCLES, 2: cycles with CS_n low and A/D stable before WE_n falls. Must be at least 1.
- WRITE_CYCLES, 4: cycles WE_n is held low. Must be at least 1.
- READ_CYCLES, 4: cycles CS_n/OE_n are low before Q is sampled. Must be at least 1.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  5  store line address.
- req_data  in  32  write data.
- clear_req  in  1  request to clear the whole store.
- req_ready  out  1  sequencer idle; a request is accepted this cycle.
- op_done  out  1  one-cycle pulse when an operation completes.
- rsp_valid  out  1  one-cycle pulse; rsp_data is valid.
- rsp_data  out  32  captured read data.
- store_A  out  5  to store A.
- store_D  out  32  to store D.
- store_CS_n  out  1  to store CS_n.
- store_WE_n  out  1  to store WE_n.
- store_OE_n  out  1  to store OE_n.
- store_Q  in  32  from store Q.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on port reset.
- Reset values (all outputs registered): state IDLE; req_ready 1 in the cycle after reset deasserts; op_done 0; rsp_valid 0; rsp_data 0; store_A 0; store_D 0; store_CS_n 1; store_WE_n 1; store_OE_n 1.
- Reset mid-operation: abort at that edge and return to IDLE with all strobes inactive. No op_done or rsp_valid is generated. A partial write is permitted to leave the addressed line undefined.
- Acceptance: a request is accepted only in IDLE. clear_req has priority over req_valid in the same cycle; the req_valid request is not accepted and must be held by the requester. Address, data and direction are latched at acceptance. Inputs are ignored outside IDLE.
- States:
  - IDLE: all strobes high; req_ready = 1.
  - W_SETUP: SETUP_CYCLES cycles. CS_n = 0, WE_n = 1, OE_n = 1. store_A and store_D hold the latched values.
  - W_PULSE: WRITE_CYCLES cycles. WE_n = 0; A/D/CS_n unchanged.
  - W_HOLD: 1 cycle. WE_n = 1, CS_n = 0, A/D held.
    - Normal write: go to IDLE with op_done = 1 in that IDLE cycle.
    - Clear sweep, line < 31: increment the line and go to W_SETUP.
    - Clear sweep, line 31: go to IDLE with op_done = 1.
  - R_WAIT: READ_CYCLES cycles. CS_n = 0, OE_n = 0, WE_n = 1. rsp_data <= store_Q at the edge ending the last cycle. Then go to IDLE with rsp_valid = 1 and op_done = 1 for that cycle.
- Clear sweep: store_D = 0 and the line counter starts at 0. The counter is 5 bits and must not wrap past 31. CS_n is driven high for zero cycles between lines; continuous CS_n low is allowed.
- Latency at defaults, counting from the acceptance edge:
  - Write: cycles 1–2 setup, 3–6 WE_n low, 7 hold; op_done and req_ready in cycle 8.
  - Read: cycles 1–4 OE_n low; rsp_valid in cycle 5.
  - Clear: 32 × 7 = 224 cycles, then op_done.
- Interface invariants:
  - store_D is 0 whenever the state is not W_SETUP, W_PULSE or W_HOLD.
  - WE_n and OE_n are never both low.
  - store_A and store_D never change while WE_n is low.
  - rsp_data holds its value until the next read completes.

Test Plan:
- Clock period is 200 ns. The bench instantiates a real store-lines block zero-filled, and checks strobe ordering on every edge.
- Reset, then write addr 0x00 data 0xDEADBEEF -> req_ready drops for 7 cycles; WE_n low exactly 4 cycles with A = 0x00 and D = 0xDEADBEEF stable; op_done in cycle 8.
- Read addr 0x00 -> rsp_valid in cycle 5 with rsp_data = 0xDEADBEEF. Read addr 0x1F -> 0x00000000.
- Write 0xCAFEBABE to 0x1F, assert clear_req and req_valid simultaneously in IDLE -> clear is taken. After 224 cycles op_done fires; reads of 0x00, 0x10 and 0x1F all return 0x00000000.
- Assert reset during cycle 4 of a write to 0x05 -> strobes high at the next edge, no op_done, req_ready 1 in the following cycle. Then write 0x12345678 to 0x05 and read back 0x12345678.
- Back-to-back: writes 0x11111111 to 0x0C and 0x22222222 to 0x0D, each issued the cycle req_ready rises -> reads return 0x11111111 and 0x22222222. req_valid toggled during busy cycles is ignored.
